sync_fifo_reader: RTL and testbench
===================================

# sync_fifo_reader

Read-side drain engine for `sync_fifo`. It pops words from the FIFO read port and presents them as a valid/ready stream. A 2-entry output buffer hides the FIFO's 1-cycle read latency, so the block sustains one word per cycle while the consumer keeps `m_ready` high. It sits between `sync_fifo` (`rd_en`/`dout`/`empty`) and any downstream stream consumer. It also keeps a running count of delivered words.

## Interface
- `DATA_W`, 8, width of FIFO data and stream data
- `CNT_W`, 16, width of the delivered-word counter
- `clk`  in  1  single clock for the block; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset; shares its source with `sync_fifo`
- `fifo_empty`  in  1  `sync_fifo.empty`
- `fifo_dout`  in  DATA_W  `sync_fifo.dout`; valid in the cycle after an accepted `rd_en`
- `fifo_rd_en`  out  1  drives `sync_fifo.rd_en`; combinational
- `m_valid`  out  DATA_W-independent, 1  stream word available; registered
- `m_data`  out  DATA_W  stream word; registered, stable while `m_valid && !m_ready`
- `m_ready`  in  1  consumer accepts the word this cycle
- `word_cnt`  out  CNT_W  number of stream handshakes since reset; wraps modulo 2^CNT_W

## Operation
- **Occupancy FSM:** states are `EMPTY` (0 words), `ONE` (1 word), `TWO` (2 words).
  - `push` = `inflight`, the registered copy of last cycle's `fifo_rd_en`.
  - `pop` = `m_valid && m_ready`.
  - Next occupancy = occupancy + `push` − `pop`.
- **Simultaneous push and pop:**
  - In `ONE`, the new word replaces the head.
  - In `TWO`, the head advances to the second slot and the new word fills the tail.
  - Order is strictly FIFO.
- **Read issue:**
  - `fifo_rd_en = !fifo_empty && !rst && (occ + inflight − pop) < 2`.
  - This rule guarantees no overflow. A push in state `TWO` without a pop is impossible; an assertion must flag it.
- **Never-overrun rule:** `fifo_rd_en` is never high while `fifo_empty` is high.
- **Outputs:**
  - `m_valid` = (occ != `EMPTY`).
  - `m_data` = head slot.
  - The head slot changes only on a pop or when loaded in `EMPTY`.
- **Counter:** `word_cnt` increments by 1 on every `pop`. At 2^CNT_W − 1 it wraps to 0 with no flag.
- **Reset values** (effective on the first edge with `rst`=1):
  - occ = `EMPTY`, `inflight` = 0, `m_valid` = 0, `m_data` = 0, `word_cnt` = 0.
  - `fifo_rd_en` = 0 while `rst` is high.
- **Reset mid-operation:** a word in flight is discarded. `inflight` clears, so a `fifo_dout` arriving the cycle after reset is not captured.

## Timing
- **Latency:** `fifo_empty` falls in cycle N → `fifo_rd_en`=1 in N → `fifo_dout` valid in N+1 → captured at the end of N+1 → `m_valid`=1 in N+2. First-word latency is 2 cycles.
- **Throughput:** 1 word/cycle while `m_ready`=1 and the FIFO stays non-empty.
- **Back-pressure:** `m_ready` low for k cycles stops issue once occ + inflight = 2. At most 2 words are held, and no words are lost.
- **Resume:** after `m_ready` rises, `fifo_rd_en` reasserts in the same cycle, because `pop` is included in the issue rule.
- **Combinational paths:** the only combinational path through the block is `fifo_empty`/`m_ready` → `fifo_rd_en`. No path exists from `m_ready` to `m_valid`.

## Structure
- **Shared package `sync_fifo_pkg`:**
  - `DATA_W` default.
  - `occ_t` enum {`EMPTY`, `ONE`, `TWO`}.
  - `FIFO_RD_LAT` = 1 constant.
- **Sub-module `rd_skid_buf`:** the 2-slot buffer plus the occupancy FSM.
  - Ports: `clk`, `rst`, `push`, `push_data`, `pop`, `occ`, `head`.
  - The top level adds the issue logic, `inflight`, and the counter.

## Test plan
- **Reset:** assert `rst` for 2 cycles with a non-empty FIFO → `fifo_rd_en`=0, `m_valid`=0, `word_cnt`=0 throughout; first `fifo_rd_en` appears the cycle after `rst` falls.
- **Streaming:** write 0x01..0x10 into the FIFO, `m_ready`=1 → 16 consecutive `m_valid` cycles with data 0x01..0x10 in order, starting 2 cycles after `empty` falls; `word_cnt`=16.
- **Back-pressure:** 8 words queued, `m_ready`=0 for 10 cycles → exactly 2 `fifo_rd_en` pulses; `m_data`=first word stays stable; after `m_ready`=1, all 8 words arrive in order with no gaps.
- **Alternating ready:** `m_ready` toggling 1/0 over 20 words → every word delivered exactly once in order; `fifo_rd_en` is never high with `fifo_empty`=1.
- **Reset mid-stream:** assert `rst` in the cycle after a `fifo_rd_en` with occ=`TWO` → next cycle `m_valid`=0, `word_cnt`=0; the in-flight word is not presented.
- **Counter wrap:** with `CNT_W`=4, deliver 17 words → `word_cnt` reads 15 after the 15th pop, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/sync_fifo_reader_pkg.sv
// sync_fifo_pkg
//   Shared definitions for the sync_fifo read-side logic.
//   DATA_W      : default data width of the FIFO and the output stream
//   occ_t       : occupancy of the 2-entry output buffer
//   FIFO_RD_LAT : cycles from an accepted rd_en to valid dout
//   occ_level() : occupancy as a small integer for arithmetic on the issue rule
package sync_fifo_pkg;

  localparam int DATA_W      = 8;
  localparam int FIFO_RD_LAT = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // Encoding is chosen so the enum value is the word count; this keeps the
  // issue arithmetic free of a decode table.
  function automatic logic [2:0] occ_level(input occ_t o);
    return {1'b0, o};
  endfunction

endpackage

// File: rtl/sync_fifo_reader_skid_buf.sv
// rd_skid_buf
//   Two-slot output buffer with occupancy FSM. Slot "head" is always the word
//   presented downstream; slot "tail" only holds data while occupancy is TWO.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : push_data is written this cycle
//   push_data  : incoming word (FIFO dout)
//   pop        : head word is consumed this cycle
//   occ        : current occupancy (registered)
//   head       : current head word (registered)
module rd_skid_buf
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = sync_fifo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output occ_t              occ,
  output logic [DATA_W-1:0] head
);

  occ_t              occ_q,  occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      EMPTY: begin
        // pop cannot occur here: the consumer only sees valid when occ != EMPTY
        if (push) begin
          head_d = push_data;
          occ_d  = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = push_data;      // old head leaves, new word takes its place
        end else if (push) begin
          tail_d = push_data;
          occ_d  = TWO;
        end else if (pop) begin
          occ_d  = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d = tail_q;         // head advances to the older tail word
          if (push) begin
            tail_d = push_data;
          end else begin
            occ_d  = ONE;
          end
        end
        // push without pop is prevented by the issue rule upstream
      end
      default: begin
        occ_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign occ  = occ_q;
  assign head = head_q;

  // A third word would overwrite live data.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(occ_q == TWO && push && !pop))
    else $error("rd_skid_buf: push into full buffer without pop");

endmodule

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader
//   Drains sync_fifo into a valid/ready stream at up to one word per cycle.
//   A 2-slot buffer absorbs the FIFO's 1-cycle read latency so reads can be
//   issued ahead of consumer demand without ever losing a word.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (shared with sync_fifo)
//   fifo_empty  : FIFO empty flag
//   fifo_dout   : FIFO read data, valid the cycle after an accepted rd_en
//   fifo_rd_en  : FIFO read strobe (combinational)
//   m_valid     : stream word available (registered)
//   m_data      : stream word (registered, held under back-pressure)
//   m_ready     : consumer accepts the word
//   word_cnt    : delivered-word count, wraps modulo 2^CNT_W
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = sync_fifo_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  // inflight marks a read issued last cycle whose data is on fifo_dout now.
  // One stage is all the pipeline needs because the FIFO latency is fixed.
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  occ_t             occ;
  logic [DATA_W-1:0] head;
  logic             push;
  logic             pop;
  logic [2:0]       level;
  logic             room;

  assign push = inflight_q;
  assign pop  = m_valid && m_ready;

  // Words held plus words on the way, after this cycle's pop. Issuing only
  // while this is below 2 bounds the buffer; counting pop lets a read go
  // out in the same cycle the consumer frees a slot.
  always_comb begin
    level = occ_level(occ) + {2'b00, inflight_q} - {2'b00, pop};
    room  = (level < 3'd2);
  end

  assign fifo_rd_en = !fifo_empty && !rst && room;

  always_comb begin
    inflight_d = fifo_rd_en;
    word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // A word on fifo_dout during reset is dropped: the buffer ignores push
  // while rst is high, and inflight_q is cleared so the next cycle does not
  // capture it either.
  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_dout),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign m_valid  = (occ != EMPTY);
  assign m_data   = head;
  assign word_cnt = word_cnt_q;

  a_no_overrun: assert property (@(posedge clk) !(fifo_rd_en && fifo_empty))
    else $error("sync_fifo_reader: read issued to empty FIFO");

endmodule

// File: tb/tb_sync_fifo_reader.sv
module tb_sync_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [15:0] wc16;

  logic       rd_en4, mv4;
  logic [7:0] md4;
  logic [3:0] wc4;

  always #5 clk = ~clk;

  sync_fifo_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .word_cnt(wc16)
  );

  sync_fifo_reader #(.DATA_W(8), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(rd_en4), .m_valid(mv4), .m_data(md4),
    .m_ready(m_ready), .word_cnt(wc4)
  );

  // FIFO stand-in: 1-cycle read latency, contents owned by the bench.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  int checks = 0;
  int failures = 0;

  int         nt, ngot, rd_pulses, overrun, twin_err;
  logic       vtrace [256];
  logic       rtrace [256];
  logic [7:0] dtrace [256];
  logic [7:0] got    [256];
  int         hs_t   [256];
  logic [3:0] cnt4   [256];

  task automatic fifo_write(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic tick(input bit rdy);
    bit hs;
    m_ready = rdy;
    #1;
    vtrace[nt] = m_valid;
    rtrace[nt] = fifo_rd_en;
    dtrace[nt] = m_data;
    if (fifo_rd_en) rd_pulses++;
    if (fifo_rd_en && fifo_empty) overrun++;
    if (rd_en4 !== fifo_rd_en || mv4 !== m_valid || md4 !== m_data) twin_err++;
    hs = m_valid && m_ready;
    if (hs) begin
      got[ngot]  = m_data;
      hs_t[ngot] = nt;
    end
    nt++;
    @(posedge clk); #1;
    if (hs) begin
      cnt4[ngot] = wc4;
      ngot++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    nt = 0; ngot = 0; rd_pulses = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) fifo_write(8'hA1 + 8'(i));
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || wc16 !== 16'd0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d: rd_en=%b m_valid=%b word_cnt=%0d, need 0/0/0",
                 c, fifo_rd_en, m_valid, wc16);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rd_en: got %b need 1", fifo_rd_en);
    end
    @(posedge clk); #1;
    nt = 0; ngot = 0; rd_pulses = 0;
    for (int c = 0; c < 8; c++) tick(1'b1);
    checks++;
    if (ngot != 3) begin
      failures++;
      $display("FAIL reset_drain_count: got %0d need 3", ngot);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== 8'hA1 + 8'(i)) begin
        failures++;
        $display("FAIL reset_drain_data[%0d]: got %h need %h", i, got[i], 8'hA1 + 8'(i));
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 16; i++) fifo_write(8'h01 + 8'(i));
    for (int c = 0; c < 20; c++) tick(1'b1);
    checks++;
    if (ngot != 16) begin
      failures++;
      $display("FAIL stream_count: got %0d need 16", ngot);
    end
    checks++;
    if (vtrace[0] !== 1'b0 || vtrace[1] !== 1'b0 || hs_t[0] != 2) begin
      failures++;
      $display("FAIL stream_latency: first valid at %0d need 2", hs_t[0]);
    end
    checks++;
    if (hs_t[15] != 17) begin
      failures++;
      $display("FAIL stream_gapless: last handshake at %0d need 17", hs_t[15]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 8'h01 + 8'(i)) begin
        failures++;
        $display("FAIL stream_data[%0d]: got %h need %h", i, got[i], 8'h01 + 8'(i));
      end
    end
    checks++;
    if (wc16 !== 16'd16 || wc4 !== 4'd0) begin
      failures++;
      $display("FAIL stream_word_cnt: got %0d/%0d need 16/0", wc16, wc4);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    for (int i = 0; i < 8; i++) fifo_write(8'h20 + 8'(i));
    for (int c = 0; c < 10; c++) tick(1'b0);
    checks++;
    if (rd_pulses != 2) begin
      failures++;
      $display("FAIL bp_rd_pulses: got %0d need 2", rd_pulses);
    end
    bad = 0;
    for (int c = 2; c < 10; c++)
      if (vtrace[c] !== 1'b1 || dtrace[c] !== 8'h20) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d cycles without valid 0x20, need 0", bad);
    end
    for (int c = 0; c < 12; c++) tick(1'b1);
    checks++;
    if (rtrace[10] !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume_rd_en: got %b need 1", rtrace[10]);
    end
    checks++;
    if (ngot != 8 || hs_t[0] != 10 || hs_t[7] != 17) begin
      failures++;
      $display("FAIL bp_drain: count %0d first %0d last %0d, need 8/10/17",
               ngot, hs_t[0], hs_t[7]);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 8'h20 + 8'(i)) begin
        failures++;
        $display("FAIL bp_data[%0d]: got %h need %h", i, got[i], 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 20; i++) fifo_write(8'h40 + 8'(i));
    for (int c = 0; c < 60; c++) tick(c % 2 == 0);
    checks++;
    if (ngot != 20) begin
      failures++;
      $display("FAIL alt_count: got %0d need 20", ngot);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (got[i] !== 8'h40 + 8'(i)) begin
        failures++;
        $display("FAIL alt_data[%0d]: got %h need %h", i, got[i], 8'h40 + 8'(i));
      end
    end
    checks++;
    if (overrun != 0) begin
      failures++;
      $display("FAIL no_overrun: %0d reads while empty, need 0", overrun);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 6; i++) fifo_write(8'h60 + 8'(i));
    for (int c = 0; c < 4; c++) tick(1'b0);
    tick(1'b1);  // occ TWO, pop frees a slot and a read issues
    checks++;
    if (rtrace[4] !== 1'b1 || ngot != 1 || got[0] !== 8'h60) begin
      failures++;
      $display("FAIL mid_pre: rd_en=%b count=%0d data=%h, need 1/1/60",
               rtrace[4], ngot, got[0]);
    end
    rst = 1'b1;
    m_ready = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_rd_en: got %b need 0", fifo_rd_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || wc16 !== 16'd0) begin
      failures++;
      $display("FAIL mid_after_rst: m_valid=%b word_cnt=%0d need 0/0", m_valid, wc16);
    end
    @(posedge clk); #1;
    nt = 0; ngot = 0;
    for (int c = 0; c < 8; c++) tick(1'b1);
    checks++;
    if (ngot != 3 || got[0] !== 8'h63) begin
      failures++;
      $display("FAIL mid_drain: count %0d first %h, need 3/63", ngot, got[0]);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) fifo_write(8'h80 + 8'(i));
    for (int c = 0; c < 22; c++) tick(1'b1);
    checks++;
    if (ngot != 17) begin
      failures++;
      $display("FAIL wrap_count: got %0d need 17", ngot);
    end
    checks++;
    if (cnt4[14] !== 4'd15 || cnt4[15] !== 4'd0 || cnt4[16] !== 4'd1) begin
      failures++;
      $display("FAIL wrap_cnt4: got %0d/%0d/%0d need 15/0/1", cnt4[14], cnt4[15], cnt4[16]);
    end
    checks++;
    if (wc16 !== 16'd17) begin
      failures++;
      $display("FAIL wrap_cnt16: got %0d need 17", wc16);
    end
    checks++;
    if (twin_err != 0) begin
      failures++;
      $display("FAIL width_variants: %0d cycles differ, need 0", twin_err);
    end
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b0;
    nt = 0; ngot = 0; rd_pulses = 0; overrun = 0; twin_err = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_alternating();
    test_reset_midstream();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
